// File: rtl/rs_cdb_wakeup.sv
`default_nettype none
`ifndef XLEN
`define XLEN 32
`endif
// ============================================================================
//  Module      : rs_cdb_wakeup
//  Description : Reservation station sitting on the CDB. Holds dispatched
//                instructions with pending operands, snoops CDB broadcasts
//                to capture operand values, and issues the lowest-index
//                fully-ready entry to a single functional unit.
//  Revision    : 1.0  initial release
// ============================================================================
module rs_cdb_wakeup #(
   parameter int RS_DEPTH = 4,
   parameter int TAG_W    = 3,
   parameter int FUNC_W   = 5,
   parameter int XLEN     = `XLEN
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          flush,
   input  logic                          cdb_valid,
   input  logic [TAG_W-1:0]              cdb_tag,
   input  logic [XLEN-1:0]               cdb_value,
   input  logic                          dispatch_valid,
   output logic                          dispatch_ready,
   input  logic [FUNC_W-1:0]             dispatch_func,
   input  logic [TAG_W-1:0]              dispatch_dest_tag,
   input  logic                          dispatch_opa_ready,
   input  logic                          dispatch_opb_ready,
   input  logic [TAG_W-1:0]              dispatch_opa_tag,
   input  logic [TAG_W-1:0]              dispatch_opb_tag,
   input  logic [XLEN-1:0]               dispatch_opa_val,
   input  logic [XLEN-1:0]               dispatch_opb_val,
   output logic                          issue_valid,
   input  logic                          issue_ready,
   output logic [FUNC_W-1:0]             issue_func,
   output logic [TAG_W-1:0]              issue_dest_tag,
   output logic [XLEN-1:0]               issue_opa,
   output logic [XLEN-1:0]               issue_opb,
   output logic [$clog2(RS_DEPTH):0]     free_count
);

   localparam int IDX_W = $clog2(RS_DEPTH);
   localparam int CNT_W = IDX_W + 1;
   localparam logic [CNT_W-1:0] C_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Entry storage
   logic [RS_DEPTH-1:0] r_valid;
   logic [RS_DEPTH-1:0] r_a_rdy;
   logic [RS_DEPTH-1:0] r_b_rdy;
   logic [FUNC_W-1:0]   r_func  [RS_DEPTH];
   logic [TAG_W-1:0]    r_dest  [RS_DEPTH];
   logic [TAG_W-1:0]    r_a_tag [RS_DEPTH];
   logic [TAG_W-1:0]    r_b_tag [RS_DEPTH];
   logic [XLEN-1:0]     r_a_val [RS_DEPTH];
   logic [XLEN-1:0]     r_b_val [RS_DEPTH];

   logic                w_sel_found;
   logic [IDX_W-1:0]    w_sel_idx;
   logic                w_free_found;
   logic [IDX_W-1:0]    w_free_idx;
   logic [CNT_W-1:0]    w_free_count;
   logic                w_issue_fire;
   logic                w_disp_fire;
   logic                w_fwd_a;
   logic                w_fwd_b;

   // Lowest-index ready entry (select) and lowest-index free entry (allocate),
   // plus the free-slot count; all from registered state only.
   always_comb begin
      w_sel_found  = 1'b0;
      w_sel_idx    = '0;
      w_free_found = 1'b0;
      w_free_idx   = '0;
      w_free_count = '0;
      for (int i = RS_DEPTH - 1; i >= 0; i--) begin
         if (r_valid[i] && r_a_rdy[i] && r_b_rdy[i]) begin
            w_sel_found = 1'b1;
            w_sel_idx   = i[IDX_W-1:0];
         end
         if (!r_valid[i]) begin
            w_free_found = 1'b1;
            w_free_idx   = i[IDX_W-1:0];
            w_free_count = w_free_count + C_ONE;
         end
      end
   end

   assign dispatch_ready = w_free_found;
   assign free_count     = w_free_count;
   assign issue_valid    = w_sel_found;
   assign issue_func     = w_sel_found ? r_func[w_sel_idx]  : '0;
   assign issue_dest_tag = w_sel_found ? r_dest[w_sel_idx]  : '0;
   assign issue_opa      = w_sel_found ? r_a_val[w_sel_idx] : '0;
   assign issue_opb      = w_sel_found ? r_b_val[w_sel_idx] : '0;

   assign w_issue_fire = w_sel_found && issue_ready;
   assign w_disp_fire  = dispatch_valid && w_free_found;
   // A pending operand whose producer broadcasts in the dispatch cycle is
   // captured directly, otherwise it would miss its only wakeup.
   assign w_fwd_a = !dispatch_opa_ready && cdb_valid && (cdb_tag == dispatch_opa_tag);
   assign w_fwd_b = !dispatch_opb_ready && cdb_valid && (cdb_tag == dispatch_opb_tag);

   // Entry update: flush squashes everything; otherwise wakeup, issue-clear
   // and dispatch-allocate. Allocation never targets the issuing slot since
   // that slot was occupied at the start of the cycle.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= '0;
         r_a_rdy <= '0;
         r_b_rdy <= '0;
         for (int i = 0; i < RS_DEPTH; i++) begin
            r_func[i]  <= '0;
            r_dest[i]  <= '0;
            r_a_tag[i] <= '0;
            r_b_tag[i] <= '0;
            r_a_val[i] <= '0;
            r_b_val[i] <= '0;
         end
      end else if (flush) begin
         r_valid <= '0;
      end else begin
         for (int i = 0; i < RS_DEPTH; i++) begin
            if (r_valid[i] && cdb_valid) begin
               if (!r_a_rdy[i] && (r_a_tag[i] == cdb_tag)) begin
                  r_a_rdy[i] <= 1'b1;
                  r_a_val[i] <= cdb_value;
               end
               if (!r_b_rdy[i] && (r_b_tag[i] == cdb_tag)) begin
                  r_b_rdy[i] <= 1'b1;
                  r_b_val[i] <= cdb_value;
               end
            end
         end
         if (w_issue_fire) begin
            r_valid[w_sel_idx] <= 1'b0;
         end
         if (w_disp_fire) begin
            r_valid[w_free_idx] <= 1'b1;
            r_func[w_free_idx]  <= dispatch_func;
            r_dest[w_free_idx]  <= dispatch_dest_tag;
            r_a_tag[w_free_idx] <= dispatch_opa_tag;
            r_b_tag[w_free_idx] <= dispatch_opb_tag;
            r_a_rdy[w_free_idx] <= dispatch_opa_ready | w_fwd_a;
            r_b_rdy[w_free_idx] <= dispatch_opb_ready | w_fwd_b;
            r_a_val[w_free_idx] <= w_fwd_a ? cdb_value : dispatch_opa_val;
            r_b_val[w_free_idx] <= w_fwd_b ? cdb_value : dispatch_opb_val;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rs_cdb_wakeup.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rs_cdb_wakeup
//  Description : Directed and random stimulus for rs_cdb_wakeup, checked
//                against an entry-list reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_rs_cdb_wakeup;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        flush;
   logic        cdb_valid;
   logic [2:0]  cdb_tag;
   logic [31:0] cdb_value;
   logic        dispatch_valid;
   logic        dispatch_ready;
   logic [4:0]  dispatch_func;
   logic [2:0]  dispatch_dest_tag;
   logic        dispatch_opa_ready, dispatch_opb_ready;
   logic [2:0]  dispatch_opa_tag, dispatch_opb_tag;
   logic [31:0] dispatch_opa_val, dispatch_opb_val;
   logic        issue_valid;
   logic        issue_ready;
   logic [4:0]  issue_func;
   logic [2:0]  issue_dest_tag;
   logic [31:0] issue_opa, issue_opb;
   logic [2:0]  free_count;

   int n_err = 0;
   int n_chk = 0;

   rs_cdb_wakeup #(.RS_DEPTH(4), .TAG_W(3), .FUNC_W(5), .XLEN(32)) dut (
      .clock(clock), .reset_n(reset_n), .flush(flush),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
      .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
      .dispatch_func(dispatch_func), .dispatch_dest_tag(dispatch_dest_tag),
      .dispatch_opa_ready(dispatch_opa_ready), .dispatch_opb_ready(dispatch_opb_ready),
      .dispatch_opa_tag(dispatch_opa_tag), .dispatch_opb_tag(dispatch_opb_tag),
      .dispatch_opa_val(dispatch_opa_val), .dispatch_opb_val(dispatch_opb_val),
      .issue_valid(issue_valid), .issue_ready(issue_ready),
      .issue_func(issue_func), .issue_dest_tag(issue_dest_tag),
      .issue_opa(issue_opa), .issue_opb(issue_opb),
      .free_count(free_count)
   );

   always #5 clock = ~clock;

   // Reference model: a list of slots, each holding an instruction or empty
   typedef struct {
      logic        v;
      logic [4:0]  func;
      logic [2:0]  dest;
      logic        ar, br;
      logic [2:0]  at, bt;
      logic [31:0] av, bv;
   } ent_t;
   ent_t m [4];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void m_clear();
      for (int i = 0; i < 4; i++) m[i] = '{default: '0};
   endfunction

   function automatic int m_sel();
      for (int i = 0; i < 4; i++)
         if (m[i].v && m[i].ar && m[i].br) return i;
      return -1;
   endfunction

   function automatic int m_first_free();
      for (int i = 0; i < 4; i++)
         if (!m[i].v) return i;
      return -1;
   endfunction

   function automatic int m_nfree();
      int n = 0;
      for (int i = 0; i < 4; i++) if (!m[i].v) n++;
      return n;
   endfunction

   // Apply one clock edge worth of spec rules to the model
   function automatic void m_update();
      int s, f;
      if (flush) begin
         for (int i = 0; i < 4; i++) m[i].v = 1'b0;
         return;
      end
      s = m_sel();
      f = m_first_free();
      if (s >= 0 && issue_ready) m[s].v = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (m[i].v && cdb_valid) begin
            if (!m[i].ar && m[i].at == cdb_tag) begin m[i].ar = 1; m[i].av = cdb_value; end
            if (!m[i].br && m[i].bt == cdb_tag) begin m[i].br = 1; m[i].bv = cdb_value; end
         end
      end
      if (dispatch_valid && f >= 0) begin
         m[f].v    = 1'b1;
         m[f].func = dispatch_func;
         m[f].dest = dispatch_dest_tag;
         m[f].at   = dispatch_opa_tag;
         m[f].bt   = dispatch_opb_tag;
         m[f].ar   = dispatch_opa_ready;
         m[f].br   = dispatch_opb_ready;
         m[f].av   = dispatch_opa_val;
         m[f].bv   = dispatch_opb_val;
         if (!dispatch_opa_ready && cdb_valid && cdb_tag == dispatch_opa_tag) begin
            m[f].ar = 1; m[f].av = cdb_value;
         end
         if (!dispatch_opb_ready && cdb_valid && cdb_tag == dispatch_opb_tag) begin
            m[f].br = 1; m[f].bv = cdb_value;
         end
      end
   endfunction

   task automatic check_model();
      int s = m_sel();
      chk("issue_valid", issue_valid, s >= 0);
      chk("issue_func", issue_func, s >= 0 ? m[s].func : 5'd0);
      chk("issue_dest", issue_dest_tag, s >= 0 ? m[s].dest : 3'd0);
      chk("issue_opa", issue_opa, s >= 0 ? m[s].av : 32'd0);
      chk("issue_opb", issue_opb, s >= 0 ? m[s].bv : 32'd0);
      chk("free_count", free_count, m_nfree());
      chk("dispatch_ready", dispatch_ready, m_nfree() != 0);
   endtask

   // Check current outputs, clock once, advance the model, settle
   task automatic tick();
      check_model();
      @(posedge clock);
      m_update();
      #1;
   endtask

   task automatic idle();
      flush = 0; cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
      dispatch_valid = 0; dispatch_func = 0; dispatch_dest_tag = 0;
      dispatch_opa_ready = 0; dispatch_opb_ready = 0;
      dispatch_opa_tag = 0; dispatch_opb_tag = 0;
      dispatch_opa_val = 0; dispatch_opb_val = 0;
      issue_ready = 0;
   endtask

   task automatic disp(input logic [4:0] f, input logic [2:0] d,
                       input logic ar, input logic [2:0] at, input logic [31:0] av,
                       input logic br, input logic [2:0] bt, input logic [31:0] bv);
      dispatch_valid = 1; dispatch_func = f; dispatch_dest_tag = d;
      dispatch_opa_ready = ar; dispatch_opa_tag = at; dispatch_opa_val = av;
      dispatch_opb_ready = br; dispatch_opb_tag = bt; dispatch_opb_val = bv;
   endtask

   initial begin
      idle();
      reset_n = 0;
      m_clear();
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_n = 1;
      chk("rst_issue_valid", issue_valid, 1'b0);
      chk("rst_free_count", free_count, 3'd4);
      chk("rst_dispatch_ready", dispatch_ready, 1'b1);
      chk("rst_issue_opa", issue_opa, 32'd0);

      // Wakeup through a later broadcast
      disp(5'd1, 3'd5, 1, 3'd0, 32'd7, 0, 3'd3, 32'd0);
      tick(); idle();
      chk("wk_not_yet", issue_valid, 1'b0);
      cdb_valid = 1; cdb_tag = 3'd3; cdb_value = 32'd42;
      tick(); idle();
      chk("wk_valid", issue_valid, 1'b1);
      chk("wk_opa", issue_opa, 32'd7);
      chk("wk_opb", issue_opb, 32'd42);
      chk("wk_dest", issue_dest_tag, 3'd5);
      issue_ready = 1;
      tick(); idle();

      // Same-cycle forward at dispatch
      disp(5'd2, 3'd1, 0, 3'd2, 32'd0, 1, 3'd0, 32'd9);
      cdb_valid = 1; cdb_tag = 3'd2; cdb_value = 32'h55;
      tick(); idle();
      chk("fwd_valid", issue_valid, 1'b1);
      chk("fwd_opa", issue_opa, 32'h55);
      chk("fwd_opb", issue_opb, 32'd9);
      issue_ready = 1;
      tick(); idle();

      // Fill, refuse a fifth, wake all under backpressure, then drain in order
      for (int i = 0; i < 4; i++) begin
         disp(5'(i), 3'(i), 0, 3'd6, 32'd0, 1, 3'd0, 32'(100 + i));
         tick();
      end
      idle();
      chk("full_free", free_count, 3'd0);
      chk("full_ready", dispatch_ready, 1'b0);
      disp(5'd9, 3'd7, 1, 3'd0, 32'd1, 1, 3'd0, 32'd2);
      tick(); idle();
      chk("full_ignored", free_count, 3'd0);
      cdb_valid = 1; cdb_tag = 3'd6; cdb_value = 32'h66;
      tick(); idle();
      chk("bp_valid", issue_valid, 1'b1);
      chk("bp_dest", issue_dest_tag, 3'd0);
      chk("bp_opa", issue_opa, 32'h66);
      tick();
      chk("bp_hold_dest", issue_dest_tag, 3'd0);
      for (int i = 0; i < 4; i++) begin
         issue_ready = 1;
         chk("drain_dest", issue_dest_tag, 3'(i));
         chk("drain_opb", issue_opb, 32'(100 + i));
         tick();
      end
      idle();
      chk("drain_free", free_count, 3'd4);
      chk("drain_empty", issue_valid, 1'b0);

      // Simultaneous dispatch + issue
      for (int i = 0; i < 4; i++) begin
         disp(5'(i), 3'(i), 1, 3'd0, 32'(10 + i), 1, 3'd0, 32'(20 + i));
         tick();
      end
      idle();
      chk("sim_full", free_count, 3'd0);
      disp(5'd7, 3'd7, 1, 3'd0, 32'd1, 1, 3'd0, 32'd2);
      issue_ready = 1;
      tick(); idle();
      chk("sim_full_refused", free_count, 3'd1);
      disp(5'd6, 3'd6, 1, 3'd0, 32'd3, 1, 3'd0, 32'd4);
      issue_ready = 1;
      tick(); idle();
      chk("sim_both", free_count, 3'd1);
      chk("sim_new_slot0", issue_dest_tag, 3'd6);
      issue_ready = 1;
      repeat (4) tick();
      idle();
      chk("sim_drained", free_count, 3'd4);

      // Flush with concurrent dispatch, broadcast and handshake
      disp(5'd1, 3'd2, 0, 3'd4, 32'd0, 1, 3'd0, 32'd1); tick();
      disp(5'd1, 3'd3, 0, 3'd4, 32'd0, 1, 3'd0, 32'd1); tick();
      disp(5'd1, 3'd5, 0, 3'd4, 32'd0, 1, 3'd0, 32'd1);
      cdb_valid = 1; cdb_tag = 3'd4; cdb_value = 32'd8;
      flush = 1; issue_ready = 1;
      tick(); idle();
      chk("flush_free", free_count, 3'd4);
      chk("flush_valid", issue_valid, 1'b0);
      cdb_valid = 1; cdb_tag = 3'd4; cdb_value = 32'd8;
      tick(); idle();
      chk("flush_stale_tag", issue_valid, 1'b0);

      // Asynchronous reset in the middle of a cycle
      for (int i = 0; i < 3; i++) begin
         disp(5'(i), 3'(i), 1, 3'd0, 32'd5, 1, 3'd0, 32'd6);
         tick();
      end
      idle();
      tick();
      chk("pre_areset_valid", issue_valid, 1'b1);
      #2 reset_n = 0;
      #1;
      chk("areset_valid", issue_valid, 1'b0);
      chk("areset_free", free_count, 3'd4);
      chk("areset_ready", dispatch_ready, 1'b1);
      chk("areset_opa", issue_opa, 32'd0);
      m_clear();
      @(negedge clock);
      reset_n = 1;

      // Random traffic against the model
      for (int k = 0; k < 1500; k++) begin
         dispatch_valid     = ($urandom_range(0, 1) == 1);
         dispatch_func      = 5'($urandom_range(0, 31));
         dispatch_dest_tag  = 3'($urandom_range(0, 7));
         dispatch_opa_ready = ($urandom_range(0, 1) == 1);
         dispatch_opb_ready = ($urandom_range(0, 1) == 1);
         dispatch_opa_tag   = 3'($urandom_range(0, 7));
         dispatch_opb_tag   = 3'($urandom_range(0, 7));
         dispatch_opa_val   = $urandom;
         dispatch_opb_val   = $urandom;
         cdb_valid          = ($urandom_range(0, 1) == 1);
         cdb_tag            = 3'($urandom_range(0, 7));
         cdb_value          = $urandom;
         issue_ready        = ($urandom_range(0, 9) < 7);
         flush              = ($urandom_range(0, 63) == 0);
         tick();
      end
      idle();
      tick();

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/rs_cdb_wakeup.md
# rs_cdb_wakeup

Reservation-station block on the receiving end of the common data bus: holds dispatched instructions whose operands are pending, snoops every CDB broadcast (tag + value + valid) to capture operand values, and issues fully-ready entries to one functional unit. It sits between dispatch and a functional unit. That unit's completed result later returns through the CDB arbiter.

## Interface
Parameters:
- RS_DEPTH, 4, number of entries (power of two, ≥2)
- TAG_W, 3, CDB/ROB tag width
- FUNC_W, 5, opaque function-code width passed through to the FU
- XLEN, `XLEN, operand width

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  squash all entries (mispredict recovery)
- cdb_valid  in  1  CDB broadcast valid this cycle
- cdb_tag  in  TAG_W  producing tag on CDB
- cdb_value  in  XLEN  result value on CDB
- dispatch_valid  in  1  new instruction offered
- dispatch_ready  out  1  at least one free entry
- dispatch_func  in  FUNC_W  function code
- dispatch_dest_tag  in  TAG_W  destination tag
- dispatch_opa_ready / dispatch_opb_ready  in  1 each  operand value already known
- dispatch_opa_tag / dispatch_opb_tag  in  TAG_W each  producer tag when not ready
- dispatch_opa_val / dispatch_opb_val  in  XLEN each  operand value when ready
- issue_valid  out  1  an entry is issuing
- issue_ready  in  1  FU accepts this cycle
- issue_func  out  FUNC_W; issue_dest_tag  out  TAG_W; issue_opa / issue_opb  out  XLEN each
- free_count  out  $clog2(RS_DEPTH)+1  number of free entries

## Operation
- Entry state: valid, func, dest_tag, and per operand {ready, tag, value}.
- Dispatch: accepted when dispatch_valid && dispatch_ready. Written into the lowest-index free entry.
- Same-cycle forward at dispatch: if an operand is not ready and cdb_valid && cdb_tag == that operand tag, the entry stores cdb_value with ready=1.
- Wakeup: each cycle with cdb_valid, every valid entry with an unready operand whose tag equals cdb_tag captures cdb_value and sets ready. Both operands may wake on the same broadcast. Tags of ready operands are ignored.
- Select: issue_valid=1 when any valid entry has both operands ready (registered state). The chosen entry is the lowest index among those. The issue_* payload comes from that entry and is combinational from registered state. The payload is all-zero when issue_valid=0.
- Issue: on issue_valid && issue_ready, the selected entry is cleared at the edge. While issue_ready=0 the selection is held stable, so no lower-index entry becomes selectable without a register update. A lower-index entry that becomes ready may preempt the selection only while no handshake has occurred; the FU samples only on the handshake.
- dispatch_ready = (free_count != 0), from registered occupancy only. An issue in the same cycle does not free a slot for dispatch that cycle.
- Simultaneous dispatch + issue: both happen, and free_count is unchanged. The dispatched entry never lands in the issuing slot, because that slot was not free at cycle start.
- flush: all valid bits are cleared at the edge. flush has priority over dispatch, wakeup and issue; an issue handshake in the flush cycle is still presented to the FU, since the FU owns its squash.

## Timing
- Reset (reset_n=0, asynchronous): all valid/ready bits = 0, payload regs = 0, issue_valid=0, issue_* = 0, dispatch_ready=1, free_count=RS_DEPTH.
- Dispatch at edge T with both operands ready → issue_valid no earlier than the cycle after T (1-cycle minimum latency).
- CDB broadcast in cycle T completing an entry → entry issuable in cycle T+1.
- Full: free_count=0 → dispatch_ready=0, and offered dispatches are ignored (no state change).
- Empty: issue_valid=0.
- Back-to-back: one issue per cycle sustained while ready entries exist and issue_ready=1.

## Test plan
- Reset mid-operation: fill 3 entries, assert reset_n=0 asynchronously → immediately issue_valid=0, free_count=4, dispatch_ready=1.
- Wakeup: dispatch {opa ready val 7, opb tag 3 unready, dest 5}; broadcast cdb_tag=3 value 42 next cycle → following cycle issue_valid=1, issue_opa=7, issue_opb=42, issue_dest_tag=5.
- Same-cycle forward: dispatch opa tag 2 unready while cdb_valid, cdb_tag=2, cdb_value=0x55 → next cycle issue_opa=0x55, issue_valid=1 (if opb ready).
- Full/backpressure: dispatch 4 entries waiting on tag 6, then offer a 5th → dispatch_ready=0, 5th ignored. Broadcast tag 6 with issue_ready=0 → issue_valid=1 with entry 0 held. Then issue_ready=1 for 4 cycles → entries 0,1,2,3 issue in order and free_count returns to 4.
- Simultaneous: when full, do dispatch + issue in the same cycle → dispatch refused. With 3 occupied, do dispatch + issue together → both occur and free_count stays 1.
- Flush: 2 waiting entries plus a concurrent dispatch and CDB broadcast with flush=1 → next cycle free_count=4, issue_valid=0. A later broadcast of the old tag issues nothing.
